// File: rtl/wb_sdram_port_arbiter.sv
// rtl/wb_sdram_port_arbiter.sv - two-master round-robin Wishbone arbiter for the SDRAM slave port
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sdram_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,

  output logic [1:0]        grant_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [1:0]    blk, blk_nxt;
  logic          req0, req1;
  logic          stall;
  logic          timeout;
  logic [CW-1:0] cnt;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // A master cut off by the watchdog stays ineligible until it drops cyc.
  assign req0 = m0_cyc_i & ~blk[0];
  assign req1 = m1_cyc_i & ~blk[1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      blk   <= 2'b00;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      blk   <= blk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    blk_nxt[0] = blk[0] & m0_cyc_i;
    blk_nxt[1] = blk[1] & m1_cyc_i;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          if (last) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
          end
        end else if (req0) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
        end
      end
      OWN0: begin
        if (timeout) begin
          state_nxt  = IDLE;
          blk_nxt[0] = m0_cyc_i;
        end else if (!m0_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (timeout) begin
          state_nxt  = IDLE;
          blk_nxt[1] = m1_cyc_i;
        end else if (!m1_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slave-side mux; everything is gated by state so reset drops s_cyc_o at once.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      OWN0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i & ~timeout;
        s_stb_o  = m0_stb_i & ~timeout;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i & ~timeout;
        m0_err_o = s_err_i | timeout;
      end
      OWN1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i & ~timeout;
        s_stb_o  = m1_stb_i & ~timeout;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i & ~timeout;
        m1_err_o = s_err_i | timeout;
      end
      default: ;
    endcase
  end

  assign stall = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (state == IDLE || s_ack_i || s_err_i || timeout) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  localparam bit TO_EN = 1'b0;

  // No watchdog: a stalled slave keeps the grant for as long as it stalls.
  logic unused_stall;
  assign unused_stall = stall;
  assign cnt = '0;
`endif

  assign timeout = TO_EN && (state != IDLE) && (cnt == CW'(TIMEOUT));

endmodule

// File: tb/tb_wb_sdram_port_arbiter.sv
// tb/tb_wb_sdram_port_arbiter.sv - directed self-checking bench for wb_sdram_port_arbiter
module tb_wb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic [31:0] m0_rdat;
  logic        m0_ack, m0_err;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic [31:0] m1_rdat;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [31:0] s_rdat = 0;
  logic        s_ack = 0, s_err = 0;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_sdram_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc); end
    checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin failures++; $display("FAIL reset_acks got=%b exp=0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    rst = 1'b0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
    tick();
    checks++; if (s_cyc !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL rst_pre_read got cyc=%b grant=%b exp cyc=1 grant=01", s_cyc, grant); end
    #2; s_ack = 1; rst = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL rst_async_cyc got=%b exp=0", s_cyc); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_async_grant got=%b exp=00", grant); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin failures++; $display("FAIL rst_async_ack got=%b%b exp=00", m0_ack, m1_ack); end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_adr = 32'h0000_0100; m1_dat = 32'hDEADBEEF;
    #1;
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL single_same_cycle got=%b exp=0", s_cyc); end
    tick();
    checks++; if (s_cyc !== 1'b1 || grant !== 2'b10) begin failures++; $display("FAIL single_grant got cyc=%b grant=%b exp cyc=1 grant=10", s_cyc, grant); end
    checks++; if (s_adr !== 32'h100 || s_wdat !== 32'hDEADBEEF || s_we !== 1'b1 || s_sel !== 4'hF) begin failures++; $display("FAIL single_data got adr=%h dat=%h we=%b sel=%h exp 00000100 deadbeef 1 f", s_adr, s_wdat, s_we, s_sel); end
    checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL single_ack_idle got=%b exp=0", m1_ack); end
    s_ack = 1; #1;
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin failures++; $display("FAIL single_ack got m1=%b m0=%b exp m1=1 m0=0", m1_ack, m0_ack); end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1;
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", s_cyc); end
    tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", grant); end
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      m0_cyc = 1; m1_cyc = 1;
      tick();
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (grant !== exp) begin failures++; $display("FAIL tie_%0d got=%b exp=%b", i, grant, exp); end
      m0_cyc = 0; m1_cyc = 0;
      tick();
    end
  endtask

  task automatic test_burst();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    s_rdat = 32'hA5A5_0000;
    tick();
    for (int b = 0; b < 8; b++) begin
      s_ack = 1; s_rdat = 32'hA5A5_0000 + b;
      #1;
      checks++; if (grant !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin failures++; $display("FAIL burst_beat_%0d got grant=%b m0_ack=%b m1_ack=%b exp 01 1 0", b, grant, m0_ack, m1_ack); end
      if (b == 7) begin
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
      end
      tick();
    end
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin failures++; $display("FAIL burst_gap got grant=%b cyc=%b exp 00 0", grant, s_cyc); end
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL burst_handover got=%b exp=10", grant); end
    m1_cyc = 0; m1_stb = 0;
    tick();
  endtask

  task automatic test_abort();
    m0_cyc = 1; m0_stb = 1;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL abort_grant got=%b exp=01", grant); end
    m0_cyc = 0;
    #1;
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL abort_cyc got=%b exp=0", s_cyc); end
    tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL abort_idle got=%b exp=00", grant); end
    s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin failures++; $display("FAIL abort_stray_ack got=%b%b exp=00", m0_ack, m1_ack); end
    s_ack = 0; m0_stb = 0;
    tick();
  endtask

  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1;
    tick();
    m1_cyc = 1; m1_stb = 1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checks++; if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin failures++; $display("FAIL to_stall_%0d got err=%b cyc=%b exp 0 1", i, m0_err, s_cyc); end
      tick();
    end
    checks++; if (m0_err !== 1'b1 || s_cyc !== 1'b0 || grant !== 2'b01) begin failures++; $display("FAIL to_fire got err=%b cyc=%b grant=%b exp 1 0 01", m0_err, s_cyc, grant); end
    tick();
    checks++; if (m0_err !== 1'b0 || grant !== 2'b00) begin failures++; $display("FAIL to_idle got err=%b grant=%b exp 0 00", m0_err, grant); end
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL to_m1_serviced got=%b exp=10", grant); end
    m0_cyc = 0; m0_stb = 0;
`else
    for (int i = 0; i < 120; i++) begin
      checks++; if (grant !== 2'b01 || m0_err !== 1'b0 || s_cyc !== 1'b1) begin failures++; $display("FAIL hold_%0d got grant=%b err=%b cyc=%b exp 01 0 1", i, grant, m0_err, s_cyc); end
      tick();
    end
    m0_cyc = 0; m0_stb = 0;
    tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL hold_idle got=%b exp=00", grant); end
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL hold_m1_serviced got=%b exp=10", grant); end
`endif
    s_err = 1; #1;
    checks++; if (m1_err !== 1'b1 || m0_err !== 1'b0) begin failures++; $display("FAIL err_pass got m1=%b m0=%b exp 1 0", m1_err, m0_err); end
    s_err = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_abort();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
